uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit; even, 8..16.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, data bits per frame; 5..9.
REQ-005 SHALL have parameter PARITY_MODE, default 1, where 0 = none, 1 = even, 2 = odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked; 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_WIDTH bits: received word, LSB first on the line.
REQ-011 SHALL have port rx_valid, output, 1 bit: rx_data and the error flags are valid.
REQ-012 SHALL have port rx_ready, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have ports parity_err, frame_err and break_det, outputs, 1 bit each: per-word status, qualified by rx_valid.
REQ-014 SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass rxd through a two-flop synchroniser; all logic uses the synchronised value.
REQ-016 SHALL generate a one-cycle tick every CYCLES_PER_TICK = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, using a free-running wrap counter.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP and BRK_WAIT.
REQ-018 In IDLE, a synchronised 1->0 edge SHALL move the FSM to START and clear the tick-in-bit counter.
REQ-019 START SHALL sample at tick OVERSAMPLE/2-1: a 0 moves to DATA; a 1 is a false start, returns to IDLE and produces no output.
REQ-020 Every later bit SHALL be sampled OVERSAMPLE ticks after the previous sample, giving mid-bit sampling.
REQ-021 DATA SHALL shift in DATA_WIDTH bits LSB first, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-022 PARITY SHALL flag parity_err when the XOR of the data bits and the parity bit is 1 (even) or 0 (odd).
REQ-023 STOP SHALL sample STOP_BITS bits; any 0 sets frame_err.
REQ-024 Frame completion SHALL occur at the last stop-bit sample, with return to IDLE in the same cycle to allow back-to-back frames.
REQ-025 rx_valid SHALL assert 1 clk after the completion sample, with rx_data and flags loaded in the same edge.
REQ-026 rx_valid SHALL hold, with data and flags stable, until a cycle where rx_valid && rx_ready, and SHALL deassert on the next edge.
REQ-027 If completion coincides with an accept cycle, the new word SHALL load and rx_valid SHALL stay 1; no overrun occurs.
REQ-028 If completion occurs while rx_valid=1 and rx_ready=0, the new word SHALL be discarded, the held word kept, and overrun_err pulsed for 1 clk.
REQ-029 Break SHALL be detected when all data bits, the parity bit (if present) and the first stop bit are 0: break_det=1 and frame_err=1 are loaded with the word, then the FSM enters BRK_WAIT.
REQ-030 BRK_WAIT SHALL return to IDLE on the first synchronised 1; no new start is detected before then.
REQ-031 parity_err SHALL load as 0 when PARITY_MODE = 0.

Reset
REQ-032 When reset_n=0, state SHALL be IDLE, all counters 0, synchroniser flops 1, and all outputs 0, including rx_data.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release, the next falling edge SHALL start a fresh frame.

Configuration
REQ-034 With UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-2, -1 and 0 relative to the nominal sample point.
REQ-035 Without UART_RX_MAJORITY_EN, each bit SHALL use the single nominal sample; timing and latency are identical in both builds.

Structure
REQ-036 Package uart_pkg SHALL hold the FSM state enum, the parity-mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD) and a parity-check function.
REQ-037 Sub-module uart_baud_tick SHALL hold the tick generator, parametrised by CLK_FREQ, BAUD_RATE and OVERSAMPLE.
REQ-038 Elaboration SHALL error if CYCLES_PER_TICK < 2, PARITY_MODE > 2, STOP_BITS is not 1 or 2, or DATA_WIDTH is outside 5..9.

Verification
REQ-039 Scenario: defaults (27 clk/tick), frame 0xA5 with parity 0 and stop 1, rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, all flags 0.
REQ-040 Scenario: 0x3C sent with parity 1 (even mode) -> rx_valid with parity_err=1 and frame_err=0.
REQ-041 Scenario: rx_ready=0, frames 0x11 then 0x22 -> rx_data holds 0x11 and overrun_err pulses once; after rx_ready=1, rx_valid drops.
REQ-042 Scenario: rxd low for 12 bit times then high -> one word 0x00 with break_det=1 and frame_err=1, and no second word.
REQ-043 Scenario: rxd low pulse of 4 ticks -> no rx_valid, FSM back in IDLE.
REQ-044 Scenario: reset_n pulsed low during data bit 3, then frame 0x5A -> outputs 0 during reset, then a correct 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM states, parity modes and the parity check.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // dataXor is the reduction XOR of the received data bits.
  function automatic logic parity_bad(input logic dataXor, input logic parBit, input int mode);
    logic sum;
    sum = dataXor ^ parBit;
    case (mode)
      PAR_EVEN: return sum;
      PAR_ODD:  return !sum;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side ready/valid bundle: the receiver drives the word and status, the consumer drives rx_ready.
interface uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  break_det;
  logic                  overrun_err;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_tick #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);
  localparam int CPT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (CPT > 2) ? $clog2(CPT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPT - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with ready/valid output, parity/frame/break status and overrun pulse.
// Build option: define UART_RX_MAJORITY_EN to vote 2-of-3 over the last three ticks at each sample point.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rxd,
  uart_rx_cfg_if.master rx
);
  localparam int CPT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] START_PT  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_PT    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (CPT < 2) begin : g_chk_cpt
    $error("uart_rx_cfg: CYCLES_PER_TICK must be at least 2");
  end
  if (PARITY_MODE > 2 || PARITY_MODE < 0) begin : g_chk_par
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_dw
    $error("uart_rx_cfg: DATA_WIDTH must be within 5..9");
  end

  logic sync1_q, sync2_q, prev_q;
  logic rxdS, tick, sampleNow, bitVal;

  rx_state_e             state_q, state_d;
  logic [TW-1:0]         tickCnt_q, tickCnt_d;
  logic [BW-1:0]         bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parBit_q, parBit_d;
  logic                  stopErr_q, stopErr_d;
  logic                  complete, cmpFrmErr, cmpBrk, cmpParErr;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, parErr_q, frmErr_q, brk_q, ovr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rxdS = sync2_q;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_o (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // Holds the two ticks preceding the current one, so the vote spans nominal-2 .. nominal.
  logic [1:0] smp_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_q <= 2'b11;
    end else if (tick) begin
      smp_q <= {smp_q[0], rxdS};
    end
  end
  assign bitVal = (smp_q[1] & smp_q[0]) | (smp_q[1] & rxdS) | (smp_q[0] & rxdS);
`else
  assign bitVal = rxdS;
`endif

  assign sampleNow = tick && (tickCnt_q == ((state_q == START) ? START_PT : BIT_PT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parBit_q  <= 1'b0;
      stopErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      parBit_q  <= parBit_d;
      stopErr_q <= stopErr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parBit_d  = parBit_q;
    stopErr_d = stopErr_q;
    complete  = 1'b0;
    cmpFrmErr = 1'b0;
    cmpBrk    = 1'b0;
    if (tick) tickCnt_d = tickCnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (prev_q && !rxdS) begin
          state_d   = START;
          tickCnt_d = '0;
          bitCnt_d  = '0;
          parBit_d  = 1'b0;
          stopErr_d = 1'b0;
        end
      end
      START: begin
        if (sampleNow) begin
          tickCnt_d = '0;
          state_d   = bitVal ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sampleNow) begin
          tickCnt_d = '0;
          shift_d   = {bitVal, shift_q[DATA_WIDTH-1:1]};
          if (bitCnt_q == LAST_DATA) begin
            bitCnt_d = '0;
            state_d  = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sampleNow) begin
          tickCnt_d = '0;
          parBit_d  = bitVal;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sampleNow) begin
          tickCnt_d = '0;
          // parBit_q stays 0 without parity, so the break test is the same in every mode.
          if (bitCnt_q == '0 && !bitVal && shift_q == '0 && !parBit_q) begin
            complete  = 1'b1;
            cmpBrk    = 1'b1;
            cmpFrmErr = 1'b1;
            state_d   = BRK_WAIT;
          end else if (bitCnt_q == LAST_STOP) begin
            complete  = 1'b1;
            cmpFrmErr = stopErr_q | !bitVal;
            state_d   = IDLE;
          end else begin
            stopErr_d = !bitVal;
            bitCnt_d  = bitCnt_q + 1'b1;
          end
        end
      end
      BRK_WAIT: begin
        if (rxdS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmpParErr = parity_bad(^shift_q, parBit_q, PARITY_MODE);

  // A completed word is taken if the holding register is empty or being accepted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      parErr_q <= 1'b0;
      frmErr_q <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (complete) begin
        if (!valid_q || rx.rx_ready) begin
          data_q   <= shift_q;
          valid_q  <= 1'b1;
          parErr_q <= cmpParErr;
          frmErr_q <= cmpFrmErr;
          brk_q    <= cmpBrk;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data     = data_q;
  assign rx.rx_valid    = valid_q;
  assign rx.parity_err  = parErr_q;
  assign rx.frame_err   = frmErr_q;
  assign rx.break_det   = brk_q;
  assign rx.overrun_err = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at default parameters: frames are modelled from the framing
// rules, expectations queued at send time and checked by an independent handshake monitor.
module tb_uart_rx_cfg;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int OS       = 16;
  localparam int CPT      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = CPT * OS;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic clk;
  logic reset_n;
  logic rxd;
  int   vectors;
  int   miscompares;
  int   validCycles;
  int   ovrSeen;
  int   ovrExp;
  bit   dropCheck;
  exp_t expQ[$];

  uart_rx_cfg_if #(.DATA_WIDTH(8)) ifc ();

  uart_rx_cfg #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS),
    .DATA_WIDTH (8),
    .PARITY_MODE(1),
    .STOP_BITS  (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rxd    (rxd),
    .rx     (ifc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Even-parity frame model: errors follow directly from bit counts and line levels.
  function automatic exp_t modelFrame(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    e.data = d;
    e.perr = (($countones(d) + int'(p)) % 2) == 1;
    e.brk  = (d == 8'h00) && !p && !s;
    e.ferr = !s || e.brk;
    return e;
  endfunction

  task automatic holdLine(input logic v, input int clocks);
    rxd = v;
    repeat (clocks) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s,
                               input int gapBits, input bit expectDrop);
    if (expectDrop) ovrExp++;
    else expQ.push_back(modelFrame(d, p, s));
    holdLine(1'b0, BIT);
    for (int i = 0; i < 8; i++) holdLine(d[i], BIT);
    holdLine(p, BIT);
    holdLine(s, BIT);
    if (gapBits > 0) holdLine(1'b1, gapBits * BIT);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 14 * BIT) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
  endtask

  // Monitor: every accepted word is compared against the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (ifc.rx_valid) validCycles++;
      if (ifc.overrun_err) ovrSeen++;
      if (dropCheck) begin
        checkOutput("valid_drop", ifc.rx_valid, 0);
        dropCheck = 1'b0;
      end
      if (ifc.rx_valid && ifc.rx_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", ifc.rx_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("rx_data", ifc.rx_data, e.data);
          checkOutput("parity_err", ifc.parity_err, e.perr);
          checkOutput("frame_err", ifc.frame_err, e.ferr);
          checkOutput("break_det", ifc.break_det, e.brk);
        end
        dropCheck = 1'b1;
      end
    end
  end

  initial begin : watchdog
    repeat (120_000) @(posedge clk);
    $display("[TB] FAIL watchdog: bench still running after 120000 cycles, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] partial;
    logic [7:0] d;
    logic       p, s;
    int         v0;
    bit         badPar, badStop;
    vectors      = 0;
    miscompares  = 0;
    validCycles  = 0;
    ovrSeen      = 0;
    ovrExp       = 0;
    dropCheck    = 1'b0;
    reset_n      = 1'b0;
    rxd          = 1'b1;
    ifc.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", ifc.rx_valid, 0);
    checkOutput("reset_data", ifc.rx_data, 0);
    checkOutput("reset_perr", ifc.parity_err, 0);
    checkOutput("reset_ferr", ifc.frame_err, 0);
    checkOutput("reset_brk", ifc.break_det, 0);
    checkOutput("reset_ovr", ifc.overrun_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    holdLine(1'b1, 2 * BIT);

    applyStimulus(8'hA5, 1'b0, 1'b1, 1, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b1, 1, 1'b0);
    drain();

    // Overrun: the second word completes while the first is still held.
    @(posedge clk);
    #1 ifc.rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b1, 1, 1'b1);
    @(negedge clk);
    checkOutput("overrun_pulses", ovrSeen, ovrExp);
    checkOutput("held_valid", ifc.rx_valid, 1);
    checkOutput("held_data", ifc.rx_data, 8'h11);
    @(posedge clk);
    #1 ifc.rx_ready = 1'b1;
    drain();

    expQ.push_back(modelFrame(8'h00, 1'b0, 1'b0));
    holdLine(1'b0, 12 * BIT);
    holdLine(1'b1, 3 * BIT);
    drain();

    v0 = validCycles;
    holdLine(1'b0, 4 * CPT);
    holdLine(1'b1, 3 * BIT);
    checkOutput("glitch_no_word", validCycles - v0, 0);

    partial = 8'hC3;
    holdLine(1'b0, BIT);
    for (int i = 0; i < 3; i++) holdLine(partial[i], BIT);
    holdLine(partial[3], BIT / 2);
    reset_n = 1'b0;
    rxd     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", ifc.rx_valid, 0);
    checkOutput("midrst_data", ifc.rx_data, 0);
    checkOutput("midrst_ferr", ifc.frame_err, 0);
    checkOutput("midrst_brk", ifc.break_det, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    holdLine(1'b1, 2 * BIT);
    applyStimulus(8'h5A, 1'b0, 1'b1, 1, 1'b0);
    drain();

    for (int n = 0; n < 6; n++) begin
      d       = 8'($urandom_range(0, 255));
      badPar  = ($urandom_range(0, 3) == 0);
      badStop = ($urandom_range(0, 4) == 0);
      p       = (^d) ^ badPar;
      s       = !badStop;
      applyStimulus(d, p, s, badStop ? 1 : int'($urandom_range(0, 2)), 1'b0);
    end
    holdLine(1'b1, 2 * BIT);
    drain();
    checkOutput("overrun_total", ovrSeen, ovrExp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
